pwm_duty_sequencer: RTL
=======================

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 Parameter DW, default 8, sets the width of duty_out and all duty config values.
REQ-002 Parameter HW, default 8, sets the width of hold_periods and the internal hold counter.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 enable  input  1  level; 1 = run the breathing sequence, 0 = force IDLE.
REQ-006 period_end  input  1  one-clk pulse from the PWM core at the end of each PWM period.
REQ-007 cfg_load  input  1  one-clk pulse; captures all cfg_* inputs.
REQ-008 cfg_min  input  DW  lowest duty value.
REQ-009 cfg_max  input  DW  highest duty value.
REQ-010 cfg_step  input  DW  duty increment/decrement per PWM period.
REQ-011 cfg_hold  input  HW  extra PWM periods to dwell at each extreme.
REQ-012 duty_out  output  DW  registered duty value for the PWM core.
REQ-013 state_out  output  3  encoded current state: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4.
REQ-014 cfg_err  output  1  sticky; 1 = last cfg_load carried cfg_min > cfg_max.
REQ-015 cycle_cnt  output  16  count of completed up/down breathing cycles.

Function
REQ-016 cfg_load shall be honoured only in IDLE; in any other state it shall be ignored and config registers unchanged.
REQ-017 An honoured cfg_load with cfg_min > cfg_max shall set cfg_err=1 and leave config registers unchanged.
REQ-018 An honoured cfg_load with cfg_min <= cfg_max shall latch the config and clear cfg_err.
REQ-019 A latched step of 0 shall be treated as 1.
REQ-020 IDLE with enable=1 and cfg_err=0: next clk -> RAMP_UP with duty_out=min.
REQ-021 IDLE with enable=1 and cfg_err=1: remain in IDLE.
REQ-022 RAMP_UP on period_end: duty_out <= duty_out+step, computed DW+1 bits wide, no wrap.
REQ-023 RAMP_UP: if the sum >= max, duty_out <= max, go to HOLD_HIGH, hold counter <= 0.
REQ-024 HOLD_HIGH on period_end: if hold counter == hold, go to RAMP_DOWN; else increment the counter.
REQ-025 HOLD_HIGH: duty_out is unchanged.
REQ-026 RAMP_DOWN on period_end: duty_out <= duty_out-step, saturated at min, no underflow.
REQ-027 RAMP_DOWN: on reaching min, go to HOLD_LOW with hold counter <= 0.
REQ-028 HOLD_LOW: same dwell rule as HOLD_HIGH; on exit go to RAMP_UP and increment cycle_cnt.
REQ-029 cycle_cnt shall wrap from 0xFFFF to 0.
REQ-030 duty_out shall change only in the clk after a period_end; latency is exactly 1 clk.
REQ-031 Without period_end, duty_out shall hold its value.
REQ-032 enable=0 in any non-IDLE state: next clk -> IDLE with duty_out=0.
REQ-033 enable=0 has priority over a simultaneous period_end.
REQ-034 enable=0 shall not clear cycle_cnt or config.
REQ-035 min == max: RAMP_UP saturates on its first period_end; the sequence alternates holds at that value.
REQ-036 Re-assertion of enable after IDLE shall restart at RAMP_UP, duty_out=min.

Reset
REQ-037 rst_n=0 shall immediately force: state IDLE, duty_out=0, cycle_cnt=0, cfg_err=0, hold counter=0.
REQ-038 rst_n=0 shall also set config to min=0, max=2^DW-1, step=1, hold=0.
REQ-039 Reset mid-sequence shall abort without waiting for period_end.
REQ-040 Release of rst_n shall take effect on the next rising clk edge.

Verification
REQ-041 Ramp case: DW=8, load min=10/max=40/step=10/hold=2, enable, 3 period_end -> duty_out 10,20,30,40; state HOLD_HIGH.
REQ-042 Dwell and wrap: same config, 3 more period_end -> RAMP_DOWN; then 3 period_end -> 30,20,10 and HOLD_LOW.
REQ-043 Cycle count: same config, 3 further period_end -> RAMP_UP, cycle_cnt=1.
REQ-044 Saturation and bad config: max=45 -> ramp 10,20,30,40,45; cfg_min=50/cfg_max=20 -> cfg_err=1, enable keeps IDLE.
REQ-045 Priority: enable=0 with period_end in RAMP_UP at duty 20 -> next clk IDLE, duty_out=0; cfg_load while running -> config unchanged.
REQ-046 Async reset: rst_n=0 between clk edges in HOLD_HIGH -> duty_out=0, state_out=0 before the next edge.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Breathing-LED duty sequencer: ramps a PWM duty value between a configured
// minimum and maximum, one step per PWM period, dwelling at each extreme.
module pwm_duty_sequencer #(
  parameter int DW = 8,
  parameter int HW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          period_end,
  input  logic          cfg_load,
  input  logic [DW-1:0] cfg_min,
  input  logic [DW-1:0] cfg_max,
  input  logic [DW-1:0] cfg_step,
  input  logic [HW-1:0] cfg_hold,
  output logic [DW-1:0] duty_out,
  output logic [2:0]    state_out,
  output logic          cfg_err,
  output logic [15:0]   cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HIGH = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LOW  = 3'd4
  } state_e;

  localparam logic [DW-1:0] ONE = DW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]   cyc_q, cyc_d;
  logic          err_q, err_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [DW-1:0] step_eff;
  logic [DW:0]   up_sum;
  logic [DW:0]   down_floor;

  // A zero step would stall the ramp forever, so it behaves as a step of one.
  assign step_eff   = (step_q == '0) ? ONE : step_q;
  assign up_sum     = {1'b0, duty_q} + {1'b0, step_eff};
  assign down_floor = {1'b0, min_q} + {1'b0, step_eff};

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    cyc_d      = cyc_q;
    err_d      = err_q;
    min_d      = min_q;
    max_d      = max_q;
    step_d     = step_q;
    hold_d     = hold_q;

    if (state_q == S_IDLE) begin
      duty_d = '0;
      if (cfg_load) begin
        if (cfg_min > cfg_max) begin
          err_d = 1'b1;
        end else begin
          err_d  = 1'b0;
          min_d  = cfg_min;
          max_d  = cfg_max;
          step_d = cfg_step;
          hold_d = cfg_hold;
        end
      end else if (enable && !err_q) begin
        state_d = S_RAMP_UP;
        duty_d  = min_q;
      end
    end else if (!enable) begin
      state_d = S_IDLE;
      duty_d  = '0;
    end else if (period_end) begin
      case (state_q)
        S_RAMP_UP: begin
          if (up_sum >= {1'b0, max_q}) begin
            duty_d     = max_q;
            state_d    = S_HOLD_HIGH;
            hold_cnt_d = '0;
          end else begin
            duty_d = up_sum[DW-1:0];
          end
        end
        S_HOLD_HIGH: begin
          if (hold_cnt_q == hold_q) state_d = S_RAMP_DOWN;
          else hold_cnt_d = hold_cnt_q + 1'b1;
        end
        S_RAMP_DOWN: begin
          // Saturate at min rather than subtracting past it.
          if ({1'b0, duty_q} <= down_floor) begin
            duty_d     = min_q;
            state_d    = S_HOLD_LOW;
            hold_cnt_d = '0;
          end else begin
            duty_d = duty_q - step_eff;
          end
        end
        S_HOLD_LOW: begin
          if (hold_cnt_q == hold_q) begin
            state_d = S_RAMP_UP;
            cyc_d   = cyc_q + 16'd1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      duty_q     <= '0;
      hold_cnt_q <= '0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      min_q      <= '0;
      max_q      <= '1;
      step_q     <= ONE;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      hold_cnt_q <= hold_cnt_d;
      cyc_q      <= cyc_d;
      err_q      <= err_d;
      min_q      <= min_d;
      max_q      <= max_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
    end
  end

  assign duty_out  = duty_q;
  assign state_out = state_q;
  assign cfg_err   = err_q;
  assign cycle_cnt = cyc_q;

endmodule
